// File: rtl/chan_fifo_pkg.sv
// Shared constants for the comm_fpga_epp channel consumer.
//   Channel addresses, control-byte bit indices, status-byte layout, and a
//   helper that packs the status byte.
package chan_fifo_pkg;

    localparam int unsigned CHAN_W = 7;

    localparam logic [CHAN_W-1:0] CHAN_DATA = 7'd0;
    localparam logic [CHAN_W-1:0] CHAN_CTRL = 7'd1;
    localparam logic [CHAN_W-1:0] CHAN_CKLO = 7'd2;
    localparam logic [CHAN_W-1:0] CHAN_CKHI = 7'd3;

    // Control-byte bit indices
    localparam int unsigned CTRL_CLR_CKSUM = 0;
    localparam int unsigned CTRL_FLUSH     = 1;

    // Status-byte layout: {full, empty, count[5:0]}
    localparam int unsigned STAT_FULL    = 7;
    localparam int unsigned STAT_EMPTY   = 6;
    localparam int unsigned STAT_COUNT_W = 6;

    function automatic logic [7:0] make_status(
        input logic                    full,
        input logic                    empty,
        input logic [STAT_COUNT_W-1:0] count
    );
        logic [7:0] s;
        s                     = '0;
        s[STAT_FULL]          = full;
        s[STAT_EMPTY]         = empty;
        s[STAT_COUNT_W-1:0]   = count;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Byte FIFO with first-word-fall-through output and synchronous flush.
//   clk, rst          clock, synchronous active-high reset
//   push, din         write a byte (ignored when full)
//   pop               drop the head byte (ignored when empty)
//   flush             discard all contents
//   dout              head byte, 8'h00 when empty
//   count/full/empty  occupancy, derived from registered state only
module sync_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [7:0]            din,
    output logic [7:0]            dout,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = empty ? 8'h00 : mem[rd_ptr];

    // Pointers wrap naturally at DEPTH since they are exactly DEPTH_LOG2 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage array carries no reset; validity is tracked by count
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/chan_fifo_cksum.sv
// Channel-side consumer for comm_fpga_epp.
//   Data channel writes push into a byte FIFO and add into a 16-bit running
//   checksum; data channel reads drain the FIFO. The control channel clears
//   the checksum and/or flushes the FIFO, and reads back a status byte.
//   clk_in, reset_in              clock, synchronous active-high reset
//   chanAddr_in                   channel selected by the EPP core
//   h2fData_in/Valid_in/Ready_out host->FPGA byte handshake
//   f2hData_out/Valid_out/Ready_in FPGA->host byte handshake (data is combinational)
//   checksum_out                  running checksum (feeds seven_seg)
//   count_out/full_out/empty_out  FIFO occupancy
module chan_fifo_cksum
    import chan_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic [6:0]            chanAddr_in,
    input  logic [7:0]            h2fData_in,
    input  logic                  h2fValid_in,
    output logic                  h2fReady_out,
    output logic [7:0]            f2hData_out,
    output logic                  f2hValid_out,
    input  logic                  f2hReady_in,
    output logic [15:0]           checksum_out,
    output logic [DEPTH_LOG2:0]   count_out,
    output logic                  full_out,
    output logic                  empty_out
);

    logic        is_data;
    logic        is_ctrl;
    logic        wr_xfer;
    logic        rd_xfer;
    logic        push;
    logic        pop;
    logic        ctrl_wr;
    logic        flush;
    logic        clr_cksum;
    logic [7:0]  fifo_dout;
    logic [15:0] checksum;

    assign is_data = (chanAddr_in == CHAN_DATA);
    assign is_ctrl = (chanAddr_in == CHAN_CTRL);

    // Only the data channel can stall; everything else is always ready/valid
    assign h2fReady_out = is_data ? ~full_out  : 1'b1;
    assign f2hValid_out = is_data ? ~empty_out : 1'b1;

    assign wr_xfer   = h2fValid_in & h2fReady_out;
    assign rd_xfer   = f2hValid_out & f2hReady_in;
    assign push      = wr_xfer & is_data;
    assign pop       = rd_xfer & is_data;
    assign ctrl_wr   = wr_xfer & is_ctrl;
    assign flush     = ctrl_wr & h2fData_in[CTRL_FLUSH];
    assign clr_cksum = ctrl_wr & h2fData_in[CTRL_CLR_CKSUM];

    sync_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk_in),
        .rst   (reset_in),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (h2fData_in),
        .dout  (fifo_dout),
        .count (count_out),
        .full  (full_out),
        .empty (empty_out)
    );

    // Running checksum, wraps modulo 2**16
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            checksum <= '0;
        end else if (clr_cksum) begin
            checksum <= '0;
        end else if (push) begin
            checksum <= checksum + {8'h00, h2fData_in};
        end
    end

    assign checksum_out = checksum;

    // Read-back mux; reads other than the data channel have no side effects
    always_comb begin
        f2hData_out = 8'h00;
        case (chanAddr_in)
            CHAN_DATA: f2hData_out = fifo_dout;
            CHAN_CTRL: f2hData_out = make_status(full_out, empty_out,
                                                 STAT_COUNT_W'(count_out));
            CHAN_CKLO: f2hData_out = checksum[7:0];
            CHAN_CKHI: f2hData_out = checksum[15:8];
            default:   f2hData_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_chan_fifo_cksum.sv
// Self-checking bench for chan_fifo_cksum: directed scenarios followed by
// randomized traffic, compared each cycle against a queue-based model.
module tb_chan_fifo_cksum;

    localparam int DEPTH = 16;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic [6:0]  chanAddr_in;
    logic [7:0]  h2fData_in;
    logic        h2fValid_in;
    logic        h2fReady_out;
    logic [7:0]  f2hData_out;
    logic        f2hValid_out;
    logic        f2hReady_in;
    logic [15:0] checksum_out;
    logic [4:0]  count_out;
    logic        full_out;
    logic        empty_out;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0]  q[$];
    int unsigned ck = 0;

    always #5 clk_in = ~clk_in;

    chan_fifo_cksum #(.DEPTH_LOG2(4)) dut (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .chanAddr_in  (chanAddr_in),
        .h2fData_in   (h2fData_in),
        .h2fValid_in  (h2fValid_in),
        .h2fReady_out (h2fReady_out),
        .f2hData_out  (f2hData_out),
        .f2hValid_out (f2hValid_out),
        .f2hReady_in  (f2hReady_in),
        .checksum_out (checksum_out),
        .count_out    (count_out),
        .full_out     (full_out),
        .empty_out    (empty_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_data(input logic [6:0] a);
        logic [7:0] s;
        int n;
        n = q.size();
        case (a)
            7'd0:    s = (n != 0) ? q[0] : 8'h00;
            7'd1:    s = {(n == DEPTH), (n == 0), 6'(n)};
            7'd2:    s = 8'(ck);
            7'd3:    s = 8'(ck >> 8);
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    // One clock: drive, check outputs against model, clock, advance model
    task automatic cyc(input logic [6:0] a, input logic hv, input logic [7:0] hd,
                       input logic fr, input logic rst);
        logic er, ev;
        chanAddr_in = a;
        h2fValid_in = hv;
        h2fData_in  = hd;
        f2hReady_in = fr;
        reset_in    = rst;
        #1;
        er = (a == 7'd0) ? (q.size() < DEPTH) : 1'b1;
        ev = (a == 7'd0) ? (q.size() != 0)    : 1'b1;
        chk("h2f_ready", 32'(h2fReady_out), 32'(er));
        chk("f2h_valid", 32'(f2hValid_out), 32'(ev));
        chk("f2h_data",  32'(f2hData_out),  32'(exp_data(a)));
        chk("count",     32'(count_out),    32'(q.size()));
        chk("full",      32'(full_out),     32'(q.size() == DEPTH));
        chk("empty",     32'(empty_out),    32'(q.size() == 0));
        chk("cksum",     32'(checksum_out), ck);
        @(posedge clk_in);
        if (rst) begin
            q.delete();
            ck = 0;
        end else if (a == 7'd0) begin
            if (ev && fr) void'(q.pop_front());
            if (hv && er) begin
                q.push_back(hd);
                ck = (ck + 32'(hd)) % 65536;
            end
        end else if (a == 7'd1 && hv) begin
            if (hd[0]) ck = 0;
            if (hd[1]) q.delete();
        end
        @(negedge clk_in);
    endtask

    task automatic peek(input logic [6:0] a);
        chanAddr_in = a;
        h2fValid_in = 1'b0;
        f2hReady_in = 1'b0;
        reset_in    = 1'b0;
        #1;
    endtask

    initial begin
        logic [6:0] a;
        logic       hv;
        int         r;

        reset_in    = 1'b1;
        chanAddr_in = '0;
        h2fData_in  = '0;
        h2fValid_in = 1'b0;
        f2hReady_in = 1'b0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);

        // Reset state and empty status
        peek(7'd1);
        chk("t1_status", 32'(f2hData_out), 32'h40);
        chk("t1_cksum",  32'(checksum_out), 32'h0);
        chk("t1_ready",  32'(h2fReady_out), 32'h1);
        chk("t1_empty",  32'(empty_out), 32'h1);

        // Small write then FWFT read-back
        for (int i = 1; i <= 3; i++) cyc(7'd0, 1'b1, 8'(i), 1'b0, 1'b0);
        peek(7'd0);
        chk("t2_count", 32'(count_out), 32'd3);
        chk("t2_cksum", 32'(checksum_out), 32'h0006);
        for (int i = 1; i <= 3; i++) begin
            cyc(7'd0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        peek(7'd0);
        chk("t2_valid", 32'(f2hValid_out), 32'h0);

        // Fill to full, then a refused 17th byte
        cyc(7'd1, 1'b1, 8'h03, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) cyc(7'd0, 1'b1, 8'hFF, 1'b0, 1'b0);
        peek(7'd1);
        chk("t3_full",   32'(full_out), 32'h1);
        chk("t3_status", 32'(f2hData_out), 32'h90);
        cyc(7'd0, 1'b1, 8'hFF, 1'b0, 1'b0);
        peek(7'd0);
        chk("t3_cksum",  32'(checksum_out), 32'h0FF0);
        chk("t3_ready",  32'(h2fReady_out), 32'h0);
        chk("t3_count",  32'(count_out), 32'd16);

        // Checksum wrap and pointer wrap ordering
        cyc(7'd1, 1'b1, 8'h03, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            cyc(7'd0, 1'b1, 8'hFF, 1'b0, 1'b0);
            cyc(7'd0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        cyc(7'd0, 1'b1, 8'hF0, 1'b0, 1'b0);
        cyc(7'd0, 1'b0, 8'h00, 1'b1, 1'b0);
        peek(7'd0);
        chk("t4_pre", 32'(checksum_out), 32'hFFF0);
        cyc(7'd0, 1'b1, 8'h20, 1'b0, 1'b0);
        peek(7'd0);
        chk("t4_wrap", 32'(checksum_out), 32'h0010);
        cyc(7'd0, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            cyc(7'd0, 1'b1, 8'(8'h41 + i), 1'b0, 1'b0);
            if (i >= 10) cyc(7'd0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        for (int i = 0; i < 10; i++) cyc(7'd0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Control: clear + flush, then clear only
        for (int i = 0; i < 5; i++) cyc(7'd0, 1'b1, 8'($urandom_range(1, 255)), 1'b0, 1'b0);
        cyc(7'd1, 1'b1, 8'h03, 1'b0, 1'b0);
        peek(7'd0);
        chk("t5_count", 32'(count_out), 32'd0);
        chk("t5_empty", 32'(empty_out), 32'h1);
        chk("t5_cksum", 32'(checksum_out), 32'h0);
        for (int i = 0; i < 3; i++) cyc(7'd0, 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        cyc(7'd1, 1'b1, 8'h01, 1'b0, 1'b0);
        peek(7'd0);
        chk("t5_keep", 32'(count_out), 32'd3);
        chk("t5_head", 32'(f2hData_out), 32'hA0);
        for (int i = 0; i < 3; i++) cyc(7'd0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Reset mid-burst, then push+pop against a full FIFO
        for (int i = 0; i < 7; i++) cyc(7'd0, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        cyc(7'd0, 1'b1, 8'hAA, 1'b1, 1'b1);
        peek(7'd0);
        chk("t6_count", 32'(count_out), 32'd0);
        chk("t6_cksum", 32'(checksum_out), 32'h0);
        chk("t6_valid", 32'(f2hValid_out), 32'h0);
        for (int i = 0; i < 16; i++) cyc(7'd0, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        cyc(7'd0, 1'b1, 8'h55, 1'b1, 1'b0);
        peek(7'd0);
        chk("t6_fullpp", 32'(count_out), 32'd15);
        cyc(7'd0, 1'b1, 8'h66, 1'b1, 1'b0);
        peek(7'd0);
        chk("t6_pp", 32'(count_out), 32'd15);
        chk("t6_head", 32'(f2hData_out), 32'hC2);
        for (int i = 0; i < 15; i++) cyc(7'd0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 5)      a = 7'd0;
            else if (r == 6) a = 7'd1;
            else if (r == 7) a = 7'd2;
            else if (r == 8) a = 7'd3;
            else             a = 7'($urandom_range(4, 127));
            hv = (a == 7'd1) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
            cyc(a, hv, 8'($urandom), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 299) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
